dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 12 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and counter width.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mem_state_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM. The read register only updates when re is high,
// so the last read word is held until the next read.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory slave: services one read/write per request with a fixed
// WAIT_CYCLES latency and stalls the pipeline until the access completes.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output mem_state_t  fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  mem_state_t        state;
  logic [WAIT_W-1:0] cnt;
  logic              wr_q, drop_q, bad_q, oor_q, zero_q;
  logic [AW-1:0]     idx_q;
  logic [31:0]       wdata_q;

  logic          req, live_oor, live_drop, live_bad, in_idle, access;
  logic          cur_wr, cur_drop, cur_bad, cur_oor;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata, ram_rdata;

  // Request handshake: a request (ren|wen) seen in IDLE is accepted in that cycle and
  // mem_stall stays high until the cycle before DONE; the requester holds its inputs
  // while mem_stall is high and advances at the DONE edge. Inputs outside IDLE are ignored.
  assign req       = mem_ren | mem_wen;
  assign live_oor  = {2'b00, mem_addr[31:2]} >= 32'(DEPTH);
  assign live_drop = (mem_addr[1:0] != 2'b00) | live_oor;
  assign live_bad  = (mem_ren & mem_wen) | live_drop;
  assign in_idle   = (state == MS_IDLE);

  // With a single wait cycle the access happens at the accept edge, so use live inputs.
  assign cur_wr    = in_idle ? mem_wen        : wr_q;
  assign cur_drop  = in_idle ? live_drop      : drop_q;
  assign cur_bad   = in_idle ? live_bad       : bad_q;
  assign cur_oor   = in_idle ? live_oor       : oor_q;
  assign cur_idx   = in_idle ? mem_addr[AW+1:2] : idx_q;
  assign cur_wdata = in_idle ? mem_dout       : wdata_q;

  assign access = (in_idle && req && (CNT_LOAD == '0)) ||
                  ((state == MS_BUSY) && (cnt == WAIT_W'(1)));

  assign mem_stall = (in_idle && req) || (state == MS_BUSY);
  assign mem_din   = zero_q ? 32'd0 : ram_rdata;
  assign fsm_state = state;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk  (clk),
    .we   (access & cur_wr & ~cur_drop),
    .re   (access & ~cur_wr),
    .addr (cur_idx),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MS_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      drop_q  <= 1'b0;
      bad_q   <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      zero_q  <= 1'b1;
      mem_err <= 1'b0;
    end else begin
      // zero_q masks the RAM read register: set after reset and for out-of-range reads.
      if (access) begin
        if (cur_bad) mem_err <= 1'b1;
        if (!cur_wr) zero_q <= cur_oor;
      end
      case (state)
        MS_IDLE: begin
          if (req) begin
            wr_q    <= mem_wen;
            drop_q  <= live_drop;
            bad_q   <= live_bad;
            oor_q   <= live_oor;
            idx_q   <= mem_addr[AW+1:2];
            wdata_q <= mem_dout;
            cnt     <= CNT_LOAD;
            state   <= (CNT_LOAD == '0) ? MS_DONE : MS_BUSY;
          end
        end
        MS_BUSY: begin
          cnt <= cnt - WAIT_W'(1);
          if (cnt == WAIT_W'(1)) state <= MS_DONE;
        end
        MS_DONE: state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 1 wait cycles) driven by directed
// cases and random accesses, checked against a word-array reference model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 64;
  localparam int NDUT  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ren   [NDUT];
  logic        wen   [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] dout  [NDUT];
  logic [31:0] din   [NDUT];
  logic        stall [NDUT];
  logic        err   [NDUT];
  mem_state_t  st    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(g == 0 ? 2 : 1)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .mem_ren  (ren[g]),
      .mem_wen  (wen[g]),
      .mem_addr (addr[g]),
      .mem_dout (dout[g]),
      .mem_din  (din[g]),
      .mem_stall(stall[g]),
      .mem_err  (err[g]),
      .fsm_state(st[g])
    );
  end

  // reference model
  logic [31:0] ram_m  [NDUT][DEPTH];
  logic [31:0] din_m  [NDUT];
  bit          err_m  [NDUT];
  int          wait_m [NDUT] = '{2, 1};
  logic [31:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on instance d; glitch changes addr/data after the first stall edge.
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] data, input bit glitch);
    int stalls;
    int idx;
    bit mis, oor;
    idx = int'(a[31:2]);
    oor = idx >= DEPTH;
    mis = a[1:0] != 2'b00;
    if (w) begin
      if (!mis && !oor) ram_m[d][idx] = data;
    end else begin
      din_m[d] = oor ? 32'd0 : ram_m[d][idx];
    end
    if ((r && w) || mis || oor) err_m[d] = 1'b1;
    exp_q.push_back(din_m[d]);

    @(negedge clk);
    ren[d] = r; wen[d] = w; addr[d] = a; dout[d] = data;
    #1;
    stalls = 0;
    while (stall[d] === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
      if (glitch && stalls == 1) begin
        addr[d] = 32'h40;
        dout[d] = 32'h1;
      end
    end
    check($sformatf("stall_cycles[%0d]", d), 32'(stalls), 32'(wait_m[d]));
    check($sformatf("done_state[%0d]", d), 32'(st[d]), 32'(MS_DONE));
    check($sformatf("din[%0d] @%h", d, a), din[d], exp_q.pop_front());
    check($sformatf("err[%0d]", d), 32'(err[d]), 32'(err_m[d]));
    ren[d] = 1'b0; wen[d] = 1'b0; addr[d] = $urandom; dout[d] = $urandom;
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s_stall[%0d]", tag, d), 32'(stall[d]), 32'd0);
      check($sformatf("%s_din[%0d]", tag, d), din[d], 32'd0);
      check($sformatf("%s_err[%0d]", tag, d), 32'(err[d]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      ren[d] = 1'b0; wen[d] = 1'b0; addr[d] = '0; dout[d] = '0;
      din_m[d] = '0; err_m[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // give every word a known value
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < DEPTH; i++) access(d, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // read after write, two wait cycles
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // single wait cycle sweep, back-to-back
    for (int i = 0; i < 8; i++) access(1, 1'b0, 1'b1, 32'(i * 4), 32'(i * 3), 1'b0);
    for (int i = 0; i < 8; i++) access(1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);

    // inputs change while busy
    access(0, 1'b0, 1'b1, 32'h30, 32'hCAFE0001, 1'b1);
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

    // misaligned write, out-of-range read, misaligned read
    access(0, 1'b0, 1'b1, 32'h13, 32'h12345678, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);

    // simultaneous read and write
    access(1, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0);
    access(1, 1'b1, 1'b1, 32'h8, 32'hA5A5F00D, 1'b0);
    access(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    // reset during the busy cycle of a write
    @(negedge clk);
    wen[0] = 1'b1; addr[0] = 32'h20; dout[0] = 32'h55;
    @(posedge clk); #1;
    check("busy_stall", 32'(stall[0]), 32'd1);
    rst = 1'b1;
    wen[0] = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      din_m[d] = '0; err_m[d] = 1'b0;
    end
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      int d, kind;
      logic [31:0] a;
      d    = $urandom_range(0, NDUT - 1);
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, DEPTH + 7) * 4);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      access(d, kind < 5 || kind == 9, kind >= 5, a, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
